// File: rtl/dfs_mode_ctrl.sv
// dfs_mode_ctrl
// Workload-driven power-mode controller for the dynamic frequency circuit.
// Counts busy cycles over windows of 2^WIN_W cycles and steps a 2-bit mode up
// or down by one level. The controller applies hysteresis (UP_TH/DN_TH), a
// minimum dwell of DWELL completed windows between automatic changes, and a
// settle period of SETTLE cycles after every mode change. mode_o drives the
// select of the glitch-free clock switch directly, so it is always registered.
//
// Build option:
//   DFS_FORCE_EN : builds the software force path (four-phase force_req/ack).
//                  Without it, force_req_i/force_mode_i are ignored and
//                  force_ack_o is tied low.
//
// Ports:
//   clk_i         always-on reference clock
//   rstn_i        asynchronous active-low reset
//   en_i          enables automatic adjustment
//   busy_i        core activity, sampled every cycle
//   force_req_i   software force request
//   force_mode_i  requested mode, stable while force_req_i is high
//   force_ack_o   force applied and settled
//   mode_o        current mode, 00 lowest power .. 11 highest power
//   mode_chg_o    one-cycle pulse in the cycle mode_o takes a new value
//   util_o        busy count of the last completed window
//
// state  | meaning
// IDLE   | automatic adjustment off, mode held
// MEAS   | counting busy cycles over the current window
// SETTLE | waiting SETTLE cycles after an automatic change
// FORCE  | software-forced mode applied, ack after SETTLE cycles

module dfs_mode_ctrl #(
    parameter int unsigned WIN_W     = 8,
    parameter int unsigned UP_TH     = 192,
    parameter int unsigned DN_TH     = 64,
    parameter int unsigned SETTLE    = 16,
    parameter int unsigned DWELL     = 2,
    parameter logic [1:0]  INIT_MODE = 2'b00
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic           en_i,
    input  logic           busy_i,
    input  logic           force_req_i,
    input  logic [1:0]     force_mode_i,
    output logic           force_ack_o,
    output logic [1:0]     mode_o,
    output logic           mode_chg_o,
    output logic [WIN_W:0] util_o
);

    localparam int UW   = WIN_W + 1;
    localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int DW_W = $clog2(DWELL + 1);

    localparam logic [UW-1:0]   UP_TH_V   = UW'(UP_TH);
    localparam logic [UW-1:0]   DN_TH_V   = UW'(DN_TH);
    localparam logic [SC_W-1:0] SETTLE_LD = SC_W'(SETTLE - 1);
    localparam logic [DW_W-1:0] DWELL_V   = DW_W'(DWELL);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEAS,
        ST_SETTLE,
        ST_FORCE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic            mode_chg_q, mode_chg_d;
    logic            force_ack_q, force_ack_d;
    logic [UW-1:0]   util_q, util_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [UW-1:0]   busy_q, busy_d;
    logic [SC_W-1:0] settle_q, settle_d;
    logic [DW_W-1:0] dwell_q, dwell_d;

    logic            force_req_eff;
    logic [1:0]      force_mode_eff;
    logic            take_force;
    logic [UW-1:0]   win_total;
    logic [DW_W-1:0] dwell_inc;
    logic            win_last;
    logic            go_up;
    logic            go_dn;

`ifdef DFS_FORCE_EN
    assign force_req_eff  = force_req_i;
    assign force_mode_eff = force_mode_i;
    assign force_ack_o    = force_ack_q;
`else
    logic unused_force;
    assign force_req_eff  = 1'b0;
    assign force_mode_eff = mode_q;
    assign force_ack_o    = 1'b0;
    assign unused_force   = ^{force_req_i, force_mode_i, force_ack_q};
`endif

    // Count including the current cycle's busy sample, so the last cycle of
    // the window is part of the decision.
    assign win_total = busy_q + UW'(busy_i);
    assign win_last  = &win_q;
    assign dwell_inc = (dwell_q >= DWELL_V) ? DWELL_V : dwell_q + 1'b1;
    assign go_up     = (dwell_inc >= DWELL_V) && (win_total >= UP_TH_V) && (mode_q != 2'b11);
    assign go_dn     = (dwell_inc >= DWELL_V) && (win_total <= DN_TH_V) && (mode_q != 2'b00);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        mode_chg_d  = 1'b0;
        force_ack_d = force_ack_q;
        util_d      = util_q;
        win_d       = win_q;
        busy_d      = busy_q;
        settle_d    = settle_q;
        dwell_d     = dwell_q;
        take_force  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                win_d  = '0;
                busy_d = '0;
                if (force_req_eff) begin
                    take_force = 1'b1;
                end else if (en_i) begin
                    state_d = ST_MEAS;
                end
            end

            ST_MEAS: begin
                if (force_req_eff) begin
                    take_force = 1'b1;
                end else if (!en_i) begin
                    state_d = ST_IDLE;
                    win_d   = '0;
                    busy_d  = '0;
                end else if (win_last) begin
                    util_d = win_total;
                    win_d  = '0;
                    busy_d = '0;
                    if (go_up || go_dn) begin
                        mode_d     = go_up ? mode_q + 2'd1 : mode_q - 2'd1;
                        mode_chg_d = 1'b1;
                        dwell_d    = '0;
                        settle_d   = SETTLE_LD;
                        state_d    = ST_SETTLE;
                    end else begin
                        dwell_d = dwell_inc;
                    end
                end else begin
                    win_d  = win_q + 1'b1;
                    busy_d = win_total;
                end
            end

            ST_SETTLE: begin
                if (settle_q == '0) begin
                    win_d  = '0;
                    busy_d = '0;
                    if (force_req_eff) begin
                        take_force = 1'b1;
                    end else begin
                        state_d = en_i ? ST_MEAS : ST_IDLE;
                    end
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end

            ST_FORCE: begin
                if (!force_req_eff) begin
                    force_ack_d = 1'b0;
                    dwell_d     = '0;
                    win_d       = '0;
                    busy_d      = '0;
                    state_d     = en_i ? ST_MEAS : ST_IDLE;
                end else if (!force_ack_q) begin
                    if (settle_q == '0) begin
                        force_ack_d = 1'b1;
                    end else begin
                        settle_d = settle_q - 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A force entry overrides any window decision made in the same cycle.
        if (take_force) begin
            state_d     = ST_FORCE;
            mode_d      = force_mode_eff;
            mode_chg_d  = (force_mode_eff != mode_q);
            force_ack_d = 1'b0;
            settle_d    = SETTLE_LD;
            win_d       = '0;
            busy_d      = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            mode_q      <= INIT_MODE;
            mode_chg_q  <= 1'b0;
            force_ack_q <= 1'b0;
            util_q      <= '0;
            win_q       <= '0;
            busy_q      <= '0;
            settle_q    <= '0;
            dwell_q     <= DWELL_V;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            mode_chg_q  <= mode_chg_d;
            force_ack_q <= force_ack_d;
            util_q      <= util_d;
            win_q       <= win_d;
            busy_q      <= busy_d;
            settle_q    <= settle_d;
            dwell_q     <= dwell_d;
        end
    end

    assign mode_o     = mode_q;
    assign mode_chg_o = mode_chg_q;
    assign util_o     = util_q;

endmodule

// File: tb/tb_dfs_mode_ctrl.sv
module tb_dfs_mode_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic       busy;
    logic       force_req;
    logic [1:0] force_mode;
    logic       force_ack;
    logic [1:0] mode;
    logic       mode_chg;
    logic [8:0] util;

`ifdef DFS_FORCE_EN
    localparam bit FORCE_ON = 1'b1;
`else
    localparam bit FORCE_ON = 1'b0;
`endif

    dfs_mode_ctrl dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .en_i         (en),
        .busy_i       (busy),
        .force_req_i  (force_req),
        .force_mode_i (force_mode),
        .force_ack_o  (force_ack),
        .mode_o       (mode),
        .mode_chg_o   (mode_chg),
        .util_o       (util)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int base   = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct {
        string      name;
        logic [1:0] mode;
        logic [8:0] util;
        logic       ack;
    } ev_t;

    ev_t exp_q[$];

    task automatic push_ev(input string n, input logic [1:0] m, input logic [8:0] u, input logic a);
        ev_t e;
        e.name = n;
        e.mode = m;
        e.util = u;
        e.ack  = a;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", n, act, exp);
        end
    endtask

    task automatic wait_to(input int k);
        while (cyc_n < base + k) @(negedge clk);
    endtask

    // Monitor: every mode_chg pulse or force_ack transition is a DUT output
    // event and must match the next expected entry.
    logic ack_prev = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        if (!rstn) begin
            ack_prev = 1'b0;
        end else begin
            if (mode_chg || (force_ack !== ack_prev)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event got mode=%0d util=%0d ack=%0d", mode, util, force_ack);
                end else begin
                    e = exp_q.pop_front();
                    if (mode !== e.mode || util !== e.util || force_ack !== e.ack) begin
                        errors++;
                        $display("FAIL %s got mode=%0d util=%0d ack=%0d want mode=%0d util=%0d ack=%0d",
                                 e.name, mode, util, force_ack, e.mode, e.util, e.ack);
                    end
                end
            end
            ack_prev = force_ack;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; en = 1'b0; busy = 1'b0; force_req = 1'b0; force_mode = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_mode", int'(mode), 0);
        chk("rst_chg", int'(mode_chg), 0);
        chk("rst_ack", int'(force_ack), 0);
        chk("rst_util", int'(util), 0);
        rstn = 1'b1;
        @(negedge clk);

        // Full-load climb: change, settle, hold (dwell 1), change, ...
        base = cyc_n;
        en = 1'b1; busy = 1'b1;
        push_ev("up_0_1", 2'd1, 9'd256, 1'b0);
        push_ev("up_1_2", 2'd2, 9'd256, 1'b0);
        push_ev("up_2_3", 2'd3, 9'd256, 1'b0);
        wait_to(1841);
        chk("sat_top_mode", int'(mode), 3);
        chk("sat_top_util", int'(util), 256);

        busy = 1'b0;
        push_ev("dn_3_2", 2'd2, 9'd0, 1'b0);
        wait_to(2113);
        for (int i = 0; i < 512; i++) begin
            if (i == 256) chk("duty50_util_a", int'(util), 128);
            busy = (i % 2 == 0);
            @(negedge clk);
        end
        chk("duty50_util_b", int'(util), 128);
        chk("duty50_mode", int'(mode), 2);

        busy = 1'b0;
        push_ev("dn_2_1", 2'd1, 9'd0, 1'b0);
        push_ev("dn_1_0", 2'd0, 9'd0, 1'b0);
        wait_to(3937);
        chk("sat_bot_mode", int'(mode), 0);
        chk("sat_bot_util", int'(util), 0);

        // Threshold boundaries: exactly 192 steps up, exactly 64 steps down.
        busy = 1'b1;
        push_ev("up_th_192", 2'd1, 9'd192, 1'b0);
        wait_to(4129);
        busy = 1'b0;
        wait_to(4465);
        busy = 1'b1;
        push_ev("dn_th_64", 2'd0, 9'd64, 1'b0);
        wait_to(4529);
        busy = 1'b0;

        // en dropped mid-window, then a fresh full window on re-enable.
        wait_to(4737);
        busy = 1'b1;
        wait_to(4837);
        en = 1'b0;
        wait_to(4845);
        chk("en_off_mode", int'(mode), 0);
        chk("en_off_util", int'(util), 64);
        wait_to(4850);
        en = 1'b1;
        wait_to(5106);
        chk("fresh_win_early", int'(util), 64);
        wait_to(5107);
        chk("fresh_win_util", int'(util), 256);
        push_ev("up_after_fresh", 2'd1, 9'd256, 1'b0);

        // Reset in the middle of SETTLE.
        wait_to(5370);
        chk("settle_mode", int'(mode), 1);
        rstn = 1'b0; en = 1'b0; busy = 1'b0;
        #1;
        chk("midrst_mode", int'(mode), 0);
        chk("midrst_chg", int'(mode_chg), 0);
        chk("midrst_ack", int'(force_ack), 0);
        chk("midrst_util", int'(util), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Software force 00 -> 11.
        base = cyc_n;
        force_req = 1'b1; force_mode = 2'b11;
        if (FORCE_ON) begin
            push_ev("force_apply", 2'd3, 9'd0, 1'b0);
            push_ev("force_ack_rise", 2'd3, 9'd0, 1'b1);
        end
        wait_to(2);
        chk("force_mode_out", int'(mode), FORCE_ON ? 3 : 0);
        wait_to(16);
        chk("force_ack_early", int'(force_ack), 0);
        wait_to(17);
        chk("force_ack_rise", int'(force_ack), FORCE_ON ? 1 : 0);
        wait_to(20);
        force_req = 1'b0;
        if (FORCE_ON) push_ev("force_ack_fall", 2'd3, 9'd0, 1'b0);
        wait_to(21);
        chk("force_ack_fall", int'(force_ack), 0);
        chk("force_mode_hold", int'(mode), FORCE_ON ? 3 : 0);

        wait_to(30);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got %0d pending want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
